// File: rtl/enc_pkg.sv
// Shared encoder defaults: synchronizer depth, debounce windows and the
// idle (detent) levels of the A/B/BTN pins. Also used by the decoder bench.
package enc_pkg;

    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_ENC_DEB_CYCLES = 1000;      // 10 us at 100 MHz
    localparam int unsigned DEF_BTN_DEB_CYCLES = 1000000;   // 10 ms at 100 MHz

    localparam logic A_IDLE_LVL   = 1'b1;
    localparam logic B_IDLE_LVL   = 1'b1;
    localparam logic BTN_IDLE_LVL = 1'b0;

    localparam int unsigned GLITCH_W = 8;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
        return (v == '1) ? v : v + GLITCH_W'(1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: SYNC_STAGES-deep synchronizer followed by a
// consecutive-mismatch counter debouncer.
//   clk, rst : clock, synchronous active-high reset
//   raw      : asynchronous pin
//   level    : debounced level (registered)
//   reject   : high in the cycle a partial count is abandoned (bounce)
module debounce_channel
    import enc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned DEB_CYCLES  = DEF_ENC_DEB_CYCLES,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic reject
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q,  cnt_d;
    logic                   level_q, level_d;
    logic                   sync_last;

    assign sync_last = sync_q[SYNC_STAGES-1];

    // Count consecutive mismatches; commit on the DEB_CYCLES-th one.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
        level_d = level_q;
        cnt_d   = '0;
        reject  = 1'b0;
        if (sync_last != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync_last;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (cnt_q != '0) begin
            // Input went back before the window filled: a bounce.
            reject = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            level_q <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/enc_input_conditioner.sv
// Rotary encoder front end: synchronizes and debounces A, B and BTN,
// produces a rising-edge strobe on the debounced button and counts
// rejected bounces.
//   clk, rst          : clock, synchronous active-high reset
//   A_raw/B_raw/BTN_raw: asynchronous pins
//   A, B, BTN         : debounced levels
//   BTN_pulse         : one-cycle strobe after BTN rises
//   glitch_cnt        : saturating count of cycles with a rejected bounce
module enc_input_conditioner
    import enc_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned ENC_DEB_CYCLES = DEF_ENC_DEB_CYCLES,
    parameter int unsigned BTN_DEB_CYCLES = DEF_BTN_DEB_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                A_raw,
    input  logic                B_raw,
    input  logic                BTN_raw,
    output logic                A,
    output logic                B,
    output logic                BTN,
    output logic                BTN_pulse,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    logic rej_a, rej_b, rej_btn;
    logic btn_lvl;

    logic                btn_prev_q,   btn_prev_d;
    logic                btn_pulse_q,  btn_pulse_d;
    logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;

    debounce_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (ENC_DEB_CYCLES),
        .RESET_VAL   (A_IDLE_LVL)
    ) u_deb_a (
        .clk    (clk),
        .rst    (rst),
        .raw    (A_raw),
        .level  (A),
        .reject (rej_a)
    );

    debounce_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (ENC_DEB_CYCLES),
        .RESET_VAL   (B_IDLE_LVL)
    ) u_deb_b (
        .clk    (clk),
        .rst    (rst),
        .raw    (B_raw),
        .level  (B),
        .reject (rej_b)
    );

    debounce_channel #(
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CYCLES  (BTN_DEB_CYCLES),
        .RESET_VAL   (BTN_IDLE_LVL)
    ) u_deb_btn (
        .clk    (clk),
        .rst    (rst),
        .raw    (BTN_raw),
        .level  (btn_lvl),
        .reject (rej_btn)
    );

    // Rising-edge strobe on debounced BTN; simultaneous rejects count once.
    always_comb begin
        btn_prev_d   = btn_lvl;
        btn_pulse_d  = btn_lvl & ~btn_prev_q;
        glitch_cnt_d = glitch_cnt_q;
        if (rej_a | rej_b | rej_btn) begin
            glitch_cnt_d = sat_inc(glitch_cnt_q);
        end
    end

    // prev resets to the idle level so no strobe can follow reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev_q   <= BTN_IDLE_LVL;
            btn_pulse_q  <= 1'b0;
            glitch_cnt_q <= '0;
        end else begin
            btn_prev_q   <= btn_prev_d;
            btn_pulse_q  <= btn_pulse_d;
            glitch_cnt_q <= glitch_cnt_d;
        end
    end

    assign BTN        = btn_lvl;
    assign BTN_pulse  = btn_pulse_q;
    assign glitch_cnt = glitch_cnt_q;

endmodule

// File: tb/tb_enc_input_conditioner.sv
// Directed bench for enc_input_conditioner with SYNC_STAGES=2,
// ENC_DEB_CYCLES=4, BTN_DEB_CYCLES=8 (A/B latency 6, BTN latency 10).
module tb_enc_input_conditioner;

    logic       clk;
    logic       rst;
    logic       A_raw, B_raw, BTN_raw;
    logic       A, B, BTN, BTN_pulse;
    logic [7:0] glitch_cnt;

    int n_vec;
    int n_err;

    enc_input_conditioner #(
        .SYNC_STAGES    (2),
        .ENC_DEB_CYCLES (4),
        .BTN_DEB_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .A_raw      (A_raw),
        .B_raw      (B_raw),
        .BTN_raw    (BTN_raw),
        .A          (A),
        .B          (B),
        .BTN        (BTN),
        .BTN_pulse  (BTN_pulse),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Quarter-step of a quadrature decoder; +1 along 11->01->00->10->11.
    function automatic int qstep(input logic [1:0] p, input logic [1:0] c);
        case ({p, c})
            4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: return 1;
            4'b01_11, 4'b00_01, 4'b10_00, 4'b11_10: return -1;
            default:                                return 0;
        endcase
    endfunction

    task automatic test_reset;
        rst = 1'b1; A_raw = 1'bx; B_raw = 1'bx; BTN_raw = 1'bx;
        tick(3);
        n_vec++; if (A !== 1'b1) begin n_err++; $display("FAIL reset_A: got %b expected 1", A); end
        n_vec++; if (B !== 1'b1) begin n_err++; $display("FAIL reset_B: got %b expected 1", B); end
        n_vec++; if (BTN !== 1'b0) begin n_err++; $display("FAIL reset_BTN: got %b expected 0", BTN); end
        n_vec++; if (BTN_pulse !== 1'b0) begin n_err++; $display("FAIL reset_pulse: got %b expected 0", BTN_pulse); end
        n_vec++; if (glitch_cnt !== 8'd0) begin n_err++; $display("FAIL reset_glitch: got %0d expected 0", glitch_cnt); end
        A_raw = 1'b1; B_raw = 1'b1; BTN_raw = 1'b0;
        rst = 1'b0;
        tick(4);
        n_vec++; if ({A, B, BTN, BTN_pulse} !== 4'b1100) begin n_err++; $display("FAIL post_reset_idle: got %b expected 1100", {A, B, BTN, BTN_pulse}); end
    endtask

    task automatic test_clean_edge;
        A_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            n_vec++;
            if (A !== ((i >= 6) ? 1'b0 : 1'b1)) begin
                n_err++; $display("FAIL clean_edge_A cycle %0d: got %b expected %b", i, A, (i >= 6) ? 1'b0 : 1'b1);
            end
            n_vec++; if (B !== 1'b1) begin n_err++; $display("FAIL clean_edge_B cycle %0d: got %b expected 1", i, B); end
        end
        n_vec++; if (glitch_cnt !== 8'd0) begin n_err++; $display("FAIL clean_edge_glitch: got %0d expected 0", glitch_cnt); end
    endtask

    task automatic test_bounce;
        B_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 4) B_raw = 1'b1;
            tick(1);
            n_vec++; if (B !== 1'b1) begin n_err++; $display("FAIL bounce_B cycle %0d: got %b expected 1", i, B); end
        end
        n_vec++; if (glitch_cnt !== 8'd1) begin n_err++; $display("FAIL bounce_glitch_1: got %0d expected 1", glitch_cnt); end
        for (int p = 2; p <= 300; p++) begin
            B_raw = 1'b0; tick(3);
            B_raw = 1'b1; tick(4);
            if (p == 100) begin
                n_vec++; if (glitch_cnt !== 8'd100) begin n_err++; $display("FAIL bounce_glitch_100: got %0d expected 100", glitch_cnt); end
            end
            if (p == 255) begin
                tick(3);
                n_vec++; if (glitch_cnt !== 8'd255) begin n_err++; $display("FAIL bounce_glitch_255: got %0d expected 255", glitch_cnt); end
            end
        end
        tick(4);
        n_vec++; if (glitch_cnt !== 8'd255) begin n_err++; $display("FAIL bounce_glitch_sat: got %0d expected 255", glitch_cnt); end
        n_vec++; if (B !== 1'b1) begin n_err++; $display("FAIL bounce_B_final: got %b expected 1", B); end
        n_vec++; if (A !== 1'b0) begin n_err++; $display("FAIL bounce_A_indep: got %b expected 0", A); end
    endtask

    task automatic test_button;
        BTN_raw = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            n_vec++;
            if (BTN !== ((i >= 10) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL btn_rise cycle %0d: got %b expected %b", i, BTN, (i >= 10) ? 1'b1 : 1'b0);
            end
            n_vec++;
            if (BTN_pulse !== ((i == 11) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL btn_pulse cycle %0d: got %b expected %b", i, BTN_pulse, (i == 11) ? 1'b1 : 1'b0);
            end
        end
        BTN_raw = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            n_vec++;
            if (BTN !== ((i >= 10) ? 1'b0 : 1'b1)) begin
                n_err++; $display("FAIL btn_fall cycle %0d: got %b expected %b", i, BTN, (i >= 10) ? 1'b0 : 1'b1);
            end
            n_vec++; if (BTN_pulse !== 1'b0) begin n_err++; $display("FAIL btn_release_pulse cycle %0d: got %b expected 0", i, BTN_pulse); end
        end
    endtask

    task automatic test_reset_mid_count;
        A_raw = 1'b1;
        tick(10);
        n_vec++; if (A !== 1'b1) begin n_err++; $display("FAIL midrst_setup_A: got %b expected 1", A); end
        A_raw = 1'b0;
        tick(4);
        n_vec++; if (A !== 1'b1) begin n_err++; $display("FAIL midrst_before_A: got %b expected 1", A); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_vec++; if (glitch_cnt !== 8'd0) begin n_err++; $display("FAIL midrst_glitch: got %0d expected 0", glitch_cnt); end
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            n_vec++;
            if (A !== ((i >= 6) ? 1'b0 : 1'b1)) begin
                n_err++; $display("FAIL midrst_A cycle %0d: got %b expected %b", i, A, (i >= 6) ? 1'b0 : 1'b1);
            end
        end
    endtask

    task automatic test_quadrature;
        logic       ha [0:49];
        logic       hb [0:49];
        logic       ea, eb;
        logic [1:0] prev;
        int         quarter;
        A_raw = 1'b1; B_raw = 1'b1;
        tick(12);
        for (int t = 0; t < 50; t++) begin
            ha[t] = !(t < 20);
            hb[t] = !(t >= 10 && t < 30);
        end
        prev    = {A, B};
        quarter = 0;
        for (int t = 0; t < 50; t++) begin
            A_raw = ha[t]; B_raw = hb[t];
            tick(1);
            ea = (t >= 5) ? ha[t-5] : 1'b1;
            eb = (t >= 5) ? hb[t-5] : 1'b1;
            n_vec++; if (A !== ea) begin n_err++; $display("FAIL quad_A cycle %0d: got %b expected %b", t + 1, A, ea); end
            n_vec++; if (B !== eb) begin n_err++; $display("FAIL quad_B cycle %0d: got %b expected %b", t + 1, B, eb); end
            quarter = quarter + qstep(prev, {A, B});
            prev    = {A, B};
        end
        n_vec++; if (quarter / 4 !== 1) begin n_err++; $display("FAIL quad_position: got %0d expected 1", quarter / 4); end
        n_vec++; if (glitch_cnt !== 8'd0) begin n_err++; $display("FAIL quad_glitch: got %0d expected 0", glitch_cnt); end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        A_raw   = 1'b1;
        B_raw   = 1'b1;
        BTN_raw = 1'b0;
        test_reset();
        test_clean_edge();
        test_bounce();
        test_button();
        test_reset_mid_count();
        test_quadrature();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
